// File: rtl/lzd_norm_ctrl_pkg.sv
// Shared FPU add/sub definitions: significand/shift widths and the barrel
// shifter's direction encoding, used by the normalization control path.
package lzd_norm_ctrl_pkg;

  localparam int SWR_DEF = 26;
  localparam int EWR_DEF = 5;

  // Matches the barrel shifter's FSM_left_right_i polarity.
  localparam logic LR_RIGHT = 1'b0;
  localparam logic LR_LEFT  = 1'b1;

  // Overflow (carry-out set) is always corrected by a single right shift.
  localparam int OVF_SHIFT = 1;

endpackage

// File: rtl/lzd_priority_enc.sv
// Combinational leading-zero counter over the SWR-1 bits below the carry-out
// position; counts zeros from bit SWR-2 down to the highest set bit.
module lzd_priority_enc
  import lzd_norm_ctrl_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EWR = EWR_DEF
) (
  input  logic [SWR-2:0] data_i,
  output logic [EWR-1:0] cnt_o,
  output logic           zero_o
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    cnt_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i <= SWR - 2; i++) begin
      if (data_i[i]) begin
        cnt_o  = EWR'(SWR - 2 - i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lzd_norm_ctrl.sv
// Two-stage normalization control: captures the add/sub significand, then
// encodes shift amount, direction and zero flag for the barrel shifter.
module lzd_norm_ctrl
  import lzd_norm_ctrl_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EWR = EWR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           valid_i,
  input  logic [SWR-1:0] Data_i,
  output logic           valid_o,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           Left_Right_o,
  output logic           Zero_flag_o
);

  logic           vld_p1_q, vld_p1_d;
  logic [SWR-1:0] data_p1_q, data_p1_d;
  logic           vld_p2_q, vld_p2_d;
  logic [EWR-1:0] shift_p2_q, shift_p2_d;
  logic           lr_p2_q, lr_p2_d;
  logic           zero_p2_q, zero_p2_d;
  logic [EWR-1:0] enc_cnt;
  logic           enc_zero;

  // Stage 1: capture the raw significand
  always_comb begin
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    if (load_i) begin
      vld_p1_d = valid_i;
      if (valid_i) data_p1_d = Data_i;
    end
  end

  lzd_priority_enc #(.SWR(SWR), .EWR(EWR)) u_enc (
    .data_i (data_p1_q[SWR-2:0]),
    .cnt_o  (enc_cnt),
    .zero_o (enc_zero)
  );

  // Stage 2: encode; bubbles leave the data outputs untouched
  always_comb begin
    vld_p2_d   = vld_p2_q;
    shift_p2_d = shift_p2_q;
    lr_p2_d    = lr_p2_q;
    zero_p2_d  = zero_p2_q;
    if (load_i) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        if (data_p1_q[SWR-1]) begin
          lr_p2_d    = LR_RIGHT;
          shift_p2_d = EWR'(OVF_SHIFT);
          zero_p2_d  = 1'b0;
        end else begin
          lr_p2_d    = LR_LEFT;
          shift_p2_d = enc_zero ? '0 : enc_cnt;
          zero_p2_d  = enc_zero;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      shift_p2_q <= '0;
      lr_p2_q    <= 1'b0;
      zero_p2_q  <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      vld_p2_q   <= vld_p2_d;
      shift_p2_q <= shift_p2_d;
      lr_p2_q    <= lr_p2_d;
      zero_p2_q  <= zero_p2_d;
    end
  end

  assign valid_o       = vld_p2_q;
  assign Shift_Value_o = shift_p2_q;
  assign Left_Right_o  = lr_p2_q;
  assign Zero_flag_o   = zero_p2_q;

endmodule

// File: doc/lzd_norm_ctrl.md
LZD_NORM_CTRL -- requirements
Module: lzd_norm_ctrl

Interface
REQ-001 The block SHALL have parameter SWR, default 26, meaning significand working width in bits (bit SWR-1 is the add/sub carry-out position).
REQ-002 The block SHALL have parameter EWR, default 5, meaning shift-value width; the block requires 2**EWR > SWR-2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port load_i, input, 1 bit, pipeline advance enable; when low, every register holds.
REQ-006 The block SHALL have port valid_i, input, 1 bit, meaning Data_i carries a new add/sub result this cycle.
REQ-007 The block SHALL have port Data_i, input, SWR bits, the unnormalized significand from the add/sub stage.
REQ-008 The block SHALL have port valid_o, output, 1 bit, meaning the outputs below are a fresh result.
REQ-009 The block SHALL have port Shift_Value_o, output, EWR bits, the normalization shift amount for the downstream barrel shifter.
REQ-010 The block SHALL have port Left_Right_o, output, 1 bit: 1 = left shift, 0 = right shift (matches the shifter's FSM_left_right_i).
REQ-011 The block SHALL have port Zero_flag_o, output, 1 bit, meaning the captured significand was all zeros.

Function
REQ-012 The block SHALL be a two-stage pipeline with latency 2 load_i-qualified cycles: S1 registers Data_i and valid_i; S2 registers the encoded result.
REQ-013 When S1 data bit SWR-1 = 1 (overflow), S2 SHALL produce Left_Right_o=0, Shift_Value_o=1, Zero_flag_o=0.
REQ-014 Otherwise, when any bit in [SWR-2:0] is 1, S2 SHALL produce Left_Right_o=1 and Shift_Value_o = number of zeros above the highest set bit, counted from bit SWR-2 (range 0..SWR-2).
REQ-015 When all SWR bits are 0, S2 SHALL produce Zero_flag_o=1, Shift_Value_o=0, Left_Right_o=1.
REQ-016 valid_o SHALL equal valid_i delayed by two load_i-high cycles; when a bubble (valid_i=0) propagates, valid_o=0 and the data outputs SHALL hold their previous values.
REQ-017 When load_i=0, S1 and S2 SHALL both hold, including valid bits; no result is lost or duplicated across a stall of any length.
REQ-018 Back-to-back valid inputs with load_i held high SHALL produce one result per cycle.
REQ-019 The S2 encoder SHALL be a priority encoder; where timing requires, a nibble-zero pre-reduction stored in S1 is permitted provided the results of REQ-013 to REQ-015 are unchanged.

Reset
REQ-020 When rst is low, the block SHALL asynchronously clear all pipeline registers: valid_o=0, Shift_Value_o=0, Left_Right_o=0, Zero_flag_o=0.
REQ-021 A reset asserted mid-operation SHALL discard both in-flight results; the first valid_o after release SHALL correspond to the first valid_i sampled after release.
REQ-022 Release of rst SHALL take effect on the next rising clk edge with no additional dead cycles.

Structure
REQ-023 SWR, EWR defaults and the Left/Right encoding constants SHALL live in the shared FPU add/sub package used by the barrel shifter.
REQ-024 The block SHALL contain one sub-module, lzd_priority_enc, which is combinational, parameterized by SWR/EWR, and outputs a count and an all-zero flag.

Verification
REQ-025 The bench SHALL cover: Data_i=26'h2000000, valid_i=1, load_i=1 -> two cycles later valid_o=1, Left_Right_o=0, Shift_Value_o=1, Zero_flag_o=0.
REQ-026 The bench SHALL cover: Data_i=26'h1000000 -> Left_Right_o=1, Shift_Value_o=0; Data_i=26'h0000001 -> Left_Right_o=1, Shift_Value_o=24.
REQ-027 The bench SHALL cover: Data_i=26'h0000000 -> Zero_flag_o=1, Shift_Value_o=0.
REQ-028 The bench SHALL cover: three back-to-back inputs 26'h0800000, 26'h0004000, 26'h2FFFFFF -> consecutive outputs of shift 1/left, 10/left, 1/right.
REQ-029 The bench SHALL cover: load_i low for 5 cycles with two results in flight -> outputs frozen; after load_i rises, both results appear in order, each exactly once.
REQ-030 The bench SHALL cover: rst pulsed low while two results are in flight -> all outputs 0 immediately; neither result emerges; the next input produces the correct result 2 cycles later.
